// File: rtl/mult_pkg.sv
// Shared constants and FSM encoding for the 4-bit shift-add multiplier.
package mult_pkg;

   localparam int N    = 4;
   localparam int ITER = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/adder4.sv
// 4-bit ripple adder used by the multiplier's add step.
module adder4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/shift_add_mult4.sv
// Sequential 4x4 unsigned multiplier: one add-and-shift step per RUN cycle,
// product registered on the final step and held until the next completion.
module shift_add_mult4
   import mult_pkg::*;
#(
   parameter int N = 4
) (
   input  logic           Clock,
   input  logic           Resetn,
   input  logic           Start,
   input  logic [N-1:0]   A,
   input  logic [N-1:0]   B,
   output logic           Busy,
   output logic           Done,
   output logic [2*N-1:0] P
);

   state_t         state, state_nxt;
   logic [N-1:0]   mcand, mplr, acc;
   logic [N-1:0]   addend, sum;
   logic           cout;
   logic [1:0]     cnt;
   logic           last;
   logic [2*N-1:0] prod_nxt;
   logic [2*N-1:0] p_q;

   assign addend = mplr[0] ? mcand : '0;

   adder4 u_add (
      .a    (acc),
      .b    (addend),
      .cin  (1'b0),
      .s    (sum),
      .cout (cout)
   );

   // {cout, sum, mplr} shifted right by one; mplr's LSB falls off
   assign prod_nxt = {cout, sum, mplr[N-1:1]};
   assign last     = (cnt == 2'(ITER - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: state_nxt = Start ? RUN : IDLE;
         RUN:        if (last) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state <= IDLE;
         mcand <= '0;
         mplr  <= '0;
         acc   <= '0;
         cnt   <= '0;
         p_q   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE, DONE: begin
               if (Start) begin
                  mcand <= A;
                  mplr  <= B;
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            RUN: begin
               {acc, mplr} <= prod_nxt;
               cnt         <= cnt + 2'd1;
               if (last) p_q <= prod_nxt;
            end
            default: ;
         endcase
      end
   end

   assign Busy = (state == RUN);
   assign Done = (state == DONE);
   assign P    = p_q;

endmodule

// File: tb/tb_shift_add_mult4.sv
// Randomized and directed bench for shift_add_mult4 against a cycle-level
// behavioural model (accept -> 4 busy cycles -> 1 done cycle, P = A*B).
module tb_shift_add_mult4;

   logic       Clock = 1'b0;
   logic       Resetn = 1'b0;
   logic       Start = 1'b0;
   logic [3:0] A = '0;
   logic [3:0] B = '0;
   logic       Busy, Done;
   logic [7:0] P;

   int checks = 0;
   int failures = 0;

   shift_add_mult4 #(.N(4)) dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .Start  (Start),
      .A      (A),
      .B      (B),
      .Busy   (Busy),
      .Done   (Done),
      .P      (P)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: cycles of busy remaining, done flag, held product
   int         m_left = 0;
   logic       m_done = 1'b0;
   logic [7:0] m_p = '0;
   logic [7:0] m_pend = '0;

   always @(posedge Clock) begin
      if (!Resetn) begin
         m_left = 0;
         m_done = 1'b0;
         m_p    = '0;
      end else if (m_left > 0) begin
         m_left--;
         m_done = (m_left == 0);
         if (m_done) m_p = m_pend;
      end else begin
         m_done = 1'b0;
         if (Start) begin
            m_left = 4;
            m_pend = 8'(int'(A) * int'(B));
         end
      end
      #1;
      chk("cyc_busy", 32'(Busy), 32'(m_left > 0));
      chk("cyc_done", 32'(Done), 32'(m_done));
      chk("cyc_p", 32'(P), 32'(m_p));
   end

   // From the negedge after acceptance, wait for Done; mode 0 quiet,
   // 1 random Start/A/B noise, 2 Start held high with A/B noise.
   task automatic wait_done(input logic [7:0] exp, input int mode, input string nm);
      int n = 0;
      int busy_n = 0;
      while (Done !== 1'b1 && n < 20) begin
         if (Busy === 1'b1) busy_n++;
         Start = (mode == 2) ? 1'b1 : (mode == 1) ? 1'($urandom) : 1'b0;
         A = 4'($urandom);
         B = 4'($urandom);
         @(negedge Clock);
         n++;
      end
      Start = 1'b0;
      chk({nm, "_done"}, 32'(Done), 32'd1);
      chk({nm, "_p"}, 32'(P), 32'(exp));
      chk({nm, "_busycnt"}, 32'(busy_n), 32'd4);
   endtask

   task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] exp, input int mode, input string nm);
      @(negedge Clock);
      Start = 1'b1; A = a; B = b;
      @(negedge Clock);
      wait_done(exp, mode, nm);
   endtask

   initial begin
      int ra, rb, gap;
      repeat (3) @(negedge Clock);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_done", 32'(Done), 32'd0);
      chk("rst_p", 32'(P), 32'h00);
      Resetn = 1'b1;

      run_op(4'd15, 4'd15, 8'hE1, 0, "max");
      @(negedge Clock);
      chk("max_hold_p", 32'(P), 32'hE1);
      chk("max_done_1cyc", 32'(Done), 32'd0);

      run_op(4'd13, 4'd11, 8'h8F, 0, "m13x11");
      run_op(4'd0, 4'd9, 8'h00, 0, "zero");

      run_op(4'd7, 4'd6, 8'h2A, 2, "ignore");

      // back-to-back accept straight from DONE
      run_op(4'd9, 4'd9, 8'h51, 0, "pre_b2b");
      Start = 1'b1; A = 4'd3; B = 4'd5;
      @(negedge Clock);
      chk("b2b_busy", 32'(Busy), 32'd1);
      wait_done(8'h0F, 0, "b2b");

      // reset in the 2nd RUN cycle aborts the operation
      @(negedge Clock);
      Start = 1'b1; A = 4'd12; B = 4'd10;
      @(negedge Clock);
      Start = 1'b0;
      @(negedge Clock);
      Resetn = 1'b0;
      Start = 1'b1;
      @(negedge Clock);
      Resetn = 1'b1;
      Start = 1'b0;
      chk("abort_busy", 32'(Busy), 32'd0);
      chk("abort_done", 32'(Done), 32'd0);
      chk("abort_p", 32'(P), 32'h00);
      for (int i = 0; i < 8; i++) begin
         @(negedge Clock);
         chk("abort_no_done", 32'(Done), 32'd0);
      end

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            run_op(4'(a), 4'(b), 8'(a * b), 0, "all");

      for (int i = 0; i < 40; i++) begin
         ra  = int'($urandom_range(0, 15));
         rb  = int'($urandom_range(0, 15));
         gap = int'($urandom_range(0, 3));
         repeat (gap) @(negedge Clock);
         run_op(4'(ra), 4'(rb), 8'(ra * rb), 1, "rand");
      end

      repeat (3) @(negedge Clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/shift_add_mult4.md
SHIFT_ADD_MULT4 -- requirements
Module: shift_add_mult4

Interface
REQ-001 SHALL have parameter: N, 4, operand width; only 4 is supported because the add datapath is the 4-bit adder4.
REQ-002 SHALL have port: Clock  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: Resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: Start  input  1  request to multiply; sampled only in IDLE or DONE.
REQ-005 SHALL have port: A  input  4  multiplicand, unsigned; sampled on the accepting edge only.
REQ-006 SHALL have port: B  input  4  multiplier, unsigned; sampled on the accepting edge only.
REQ-007 SHALL have port: Busy  output  1  high while an operation is in RUN.
REQ-008 SHALL have port: Done  output  1  one-cycle pulse marking a new valid P.
REQ-009 SHALL have port: P  output  8  product A*B, unsigned; held between completions.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, DONE.
REQ-011 SHALL, in IDLE with Start=1 at an edge, latch A into the multiplicand register, latch B into the multiplier register, clear the 4-bit upper accumulator and carry, set the iteration counter to 0, and go to RUN.
REQ-012 SHALL, in IDLE with Start=0, remain in IDLE.
REQ-013 SHALL, on each RUN edge, add the multiplicand to the upper accumulator through adder4 (carry-in 0) if the multiplier LSB is 1, else add 0.
REQ-014 SHALL, on the same edge, shift the 9-bit value {carry-out, sum, multiplier} right by one bit, so the multiplier register collects the low product bits.
REQ-015 SHALL increment the 2-bit iteration counter each RUN edge and go to DONE on the edge that completes iteration 3 (exactly 4 RUN cycles).
REQ-016 SHALL load P with {upper accumulator, multiplier register} on the RUN-to-DONE edge only; P SHALL NOT change at any other time except reset.
REQ-017 SHALL assert Busy=1 for exactly the 4 RUN cycles and 0 otherwise.
REQ-018 SHALL assert Done=1 only in DONE, which lasts exactly one cycle.
REQ-019 SHALL treat DONE with Start=1 identically to IDLE with Start=1 (back-to-back accept, straight to RUN); DONE with Start=0 SHALL go to IDLE.
REQ-020 SHALL ignore Start, A and B while in RUN; a changed A or B mid-operation SHALL NOT affect the result.
REQ-021 SHALL have latency such that Start accepted at edge t0 gives Busy=1 after edges t0..t0+3, and Done=1 and P valid after edge t0+4.
REQ-022 SHALL produce the exact unsigned product for all 256 operand pairs; the maximum is 15*15=225 (0xE1); no overflow is possible in 8 bits.

Reset
REQ-023 SHALL, when Resetn=0 at a rising edge, set the state to IDLE and force Busy=0, Done=0 and P=8'h00, with all internal registers cleared.
REQ-024 SHALL, on reset during RUN or DONE, abort the operation with no Done pulse and no P update.
REQ-025 SHALL ignore Start on any edge where Resetn=0.

Structure
REQ-026 SHALL place the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10), N=4 and ITER=4 in the shared package mult_pkg.
REQ-027 SHALL instantiate exactly one adder4 for the add step; no `*` operator SHALL be used.
REQ-028 SHALL use a single clocked process for state and datapath, and a combinational add path only.

Verification
REQ-029 SHALL cover: A=15, B=15, Start pulse -> Busy for 4 cycles, then Done=1 for one cycle with P=0xE1.
REQ-030 SHALL cover: A=13, B=11 -> P=0x8F; then A=0, B=9 -> P=0x00 with a Done pulse still issued.
REQ-031 SHALL cover: A=7, B=6 accepted, then Start held high and A, B changed during RUN -> P=0x2A, Start ignored until DONE.
REQ-032 SHALL cover: Start high in the DONE cycle with A=3, B=5 after a prior op -> RUN immediately, next P=0x0F, no IDLE cycle between.
REQ-033 SHALL cover: Resetn=0 for one edge in the 2nd RUN cycle -> Busy=0, Done=0, P=0x00; no Done pulse follows.
REQ-034 SHALL cover: all 256 pairs run sequentially -> P equals A*B on every Done pulse.
